prescaler_bank: RTL and testbench

//   Multi-channel, runtime-programmable clock prescaler.

---
 rtl/prescaler_pkg.sv | 15 +
 rtl/prescaler_channel.sv | 109 ++++++++++
 rtl/prescaler_bank.sv | 60 ++++++
 tb/tb_prescaler_bank.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/prescaler_pkg.sv
// Shared constants and helpers for the prescaler bank.
//   CNT_W_DEF       default divide-value / counter width
//   DEFAULT_DIV_DEF divide value loaded into every channel at reset
//   ch_width()      width of the channel-select field for a given channel count
package prescaler_pkg;

  localparam int CNT_W_DEF       = 8;
  localparam int DEFAULT_DIV_DEF = 4;

  // At least one bit even for a single channel so the select port always exists.
  function automatic int ch_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/prescaler_channel.sv
// One prescaler channel: counter, active/shadow divide value, pending flag,
// registered clock output and period tick.
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   en          channel enable
//   load        write strobe for this channel's shadow divide value
//   load_val    new divide value
//   clk_out     prescaled clock, high for floor(D/2) cycles of each period
//   tick        one-cycle strobe in the first cycle of each period
//   pending     a shadow value is waiting to become active
module prescaler_channel
  import prescaler_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  logic [CNT_W-1:0] cnt, active, shadow;
  // run: the first enabled edge has been seen (that edge only arms the counter).
  // primed: the first period boundary has passed, so clk_out may go high.
  logic             run, primed;

  logic [CNT_W-1:0] cnt_n, active_n, shadow_n, cnt_inc, half_next, half_cur;
  logic             run_n, primed_n, clk_n, tick_n, pending_n;
  logic             wrap, apply;

  // Next-state logic: counting, period boundary, shadow-to-active transfer.
  always_comb begin
    cnt_n     = cnt;
    active_n  = active;
    shadow_n  = shadow;
    run_n     = run;
    primed_n  = primed;
    clk_n     = 1'b0;
    tick_n    = 1'b0;
    pending_n = pending;
    cnt_inc   = cnt + CNT_W'(1);
    wrap      = run && en && (active != '0) && (cnt == (active - CNT_W'(1)));
    // pending is registered, so a write seen on a boundary edge waits for the next boundary.
    apply     = pending && (!en || (active <= CNT_W'(1)) || wrap);
    half_cur  = active >> 1;
    // A value applied at a boundary already shapes the period starting there.
    half_next = apply ? (shadow >> 1) : half_cur;

    if (!en || (active == '0)) begin
      cnt_n    = '0;
      run_n    = 1'b0;
      primed_n = 1'b0;
    end else if (!run) begin
      run_n = 1'b1;
      cnt_n = '0;
    end else if (wrap) begin
      cnt_n    = '0;
      tick_n   = 1'b1;
      primed_n = 1'b1;
      clk_n    = (half_next != '0);
    end else begin
      cnt_n = cnt_inc;
      clk_n = primed && (cnt_inc < half_cur);
    end

    if (apply) begin
      active_n  = shadow;
      pending_n = 1'b0;
    end else begin
      active_n  = active;
    end

    if (load) begin
      shadow_n  = load_val;
      pending_n = 1'b1;
    end else begin
      shadow_n  = shadow;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      active  <= CNT_W'(DEFAULT_DIV);
      shadow  <= CNT_W'(DEFAULT_DIV);
      run     <= 1'b0;
      primed  <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pending <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      active  <= active_n;
      shadow  <= shadow_n;
      run     <= run_n;
      primed  <= primed_n;
      clk_out <= clk_n;
      tick    <= tick_n;
      pending <= pending_n;
    end
  end

endmodule

// File: rtl/prescaler_bank.sv
// Multi-channel runtime-programmable clock prescaler.
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   ch_en       per-channel enable
//   div_wr      divide-value write strobe
//   div_ch      target channel of the write (values >= N_CH are ignored)
//   div_val     new divide value
//   clk_out     per-channel prescaled clock (registered)
//   tick        per-channel period-start strobe (registered)
//   pending     per-channel written-but-not-applied flag
module prescaler_bank
  import prescaler_pkg::*;
#(
  parameter int  N_CH        = 4,
  parameter int  CNT_W       = CNT_W_DEF,
  parameter int  DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int CH_W        = ch_width(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             div_wr,
  input  logic [CH_W-1:0]  div_ch,
  input  logic [CNT_W-1:0] div_val,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  pending
);

  logic [N_CH-1:0] load;

  // Write-port decode; out-of-range channel numbers select nothing.
  always_comb begin
    load = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (div_wr && (div_ch == CH_W'(i))) begin
        load[i] = 1'b1;
      end else begin
        load[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    prescaler_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (ch_en[g]),
      .load     (load[g]),
      .load_val (div_val),
      .clk_out  (clk_out[g]),
      .tick     (tick[g]),
      .pending  (pending[g])
    );
  end

endmodule

// File: tb/tb_prescaler_bank.sv
// Scoreboard bench for prescaler_bank. Stimulus pushes hand-computed per-cycle
// expectations (one char per cycle: '1', '0' or '-' for don't care); the monitor
// compares them against the outputs observed on the falling clock edge.
module tb_prescaler_bank;
  import prescaler_pkg::*;

  localparam int N_CH  = 5;
  localparam int CNT_W = 8;
  localparam int CH_W  = ch_width(N_CH);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_CH-1:0]  ch_en;
  logic             div_wr;
  logic [CH_W-1:0]  div_ch;
  logic [CNT_W-1:0] div_val;
  logic [N_CH-1:0]  clk_out, tick, pending;
  logic             chk_pulse = 1'b0;

  prescaler_bank #(.N_CH(N_CH), .CNT_W(CNT_W), .DEFAULT_DIV(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ch_en   (ch_en),
    .div_wr  (div_wr),
    .div_ch  (div_ch),
    .div_val (div_val),
    .clk_out (clk_out),
    .tick    (tick),
    .pending (pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int  cyc;
    int  ch;
    int  tid;
    byte c;
    byte t;
    byte p;
  } item_t;

  item_t sb[$];
  int n_vec = 0;
  int n_bad = 0;
  int cur_tid = 0;

  function automatic string rep(input string c, input int n);
    string s = "";
    for (int i = 0; i < n; i++) s = {s, c};
    return s;
  endfunction

  task automatic expect_win(input int ch, input string cs, input string ts, input string ps,
                            input int start);
    item_t it;
    for (int i = 0; i < cs.len(); i++) begin
      it.cyc = cyc + start + i;
      it.ch  = ch;
      it.tid = cur_tid;
      it.c   = cs[i];
      it.t   = ts[i];
      it.p   = ps[i];
      sb.push_back(it);
    end
  endtask

  function automatic bit mism(input byte e, input logic a);
    return (e != "-") && (a !== (e == "1"));
  endfunction

  // Monitor: compare every expectation that falls due this cycle.
  always @(negedge clk or posedge chk_pulse) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        n_vec++;
        if (sb[i].cyc < cyc ||
            mism(sb[i].c, clk_out[sb[i].ch]) ||
            mism(sb[i].t, tick[sb[i].ch]) ||
            mism(sb[i].p, pending[sb[i].ch])) begin
          n_bad++;
          $display("FAIL test%0d ch%0d cyc%0d: got clk_out=%b tick=%b pending=%b, want %c%c%c",
                   sb[i].tid, sb[i].ch, sb[i].cyc, clk_out[sb[i].ch], tick[sb[i].ch],
                   pending[sb[i].ch], sb[i].c, sb[i].t, sb[i].p);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int ch, input int val);
    div_wr  = 1'b1;
    div_ch  = CH_W'(ch);
    div_val = CNT_W'(val);
  endtask

  int r0, c0;

  initial begin
    rst_n   = 1'b0;
    ch_en   = 5'b00001;
    div_wr  = 1'b0;
    div_ch  = '0;
    div_val = '0;

    // Test 1: outputs low in reset, then ch0 at the default divide of 4.
    cur_tid = 1;
    step(1);
    for (int ch = 0; ch < N_CH; ch++) expect_win(ch, "000", "000", "000", 1);
    step(3);
    rst_n = 1'b1;
    r0 = cyc;
    expect_win(0, "000011001100110011", "000010001000100010", rep("0", 18), 1);
    step(18);

    // Test 2: D=5 written to ch1 mid-period; old period completes, then 2 high / 3 low.
    cur_tid = 2;
    ch_en[1] = 1'b1;
    expect_win(1, "00001100110001100011", "00001000100001000010",
               {rep("0", 6), "11", rep("0", 12)}, 1);
    step(6);
    wr(1, 5);
    step(1);
    div_wr = 1'b0;
    step(13);

    // Test 3: D=0 then D=1 on disabled/stopped ch2, each applied the edge after the write.
    cur_tid = 3;
    wr(2, 0);
    expect_win(2, rep("0", 14), {rep("0", 11), "111"}, {"1", rep("0", 7), "1", rep("0", 5)}, 1);
    step(1);
    div_wr = 1'b0;
    step(1);
    ch_en[2] = 1'b1;
    step(6);
    wr(2, 1);
    step(1);
    div_wr = 1'b0;
    step(5);

    // Test 4: write sampled on ch0's wrap edge waits one period; last of two writes wins.
    cur_tid = 4;
    for (int k = 0; k < 4 && ((cyc - r0) % 4) != 0; k++) step(1);
    c0 = cyc;
    wr(0, 6);
    expect_win(0, "110011100010010010", "100010000010010010",
               {"1111", "00", "1111", rep("0", 8)}, 1);
    step(1);
    div_wr = 1'b0;
    step(5);
    wr(0, 7);
    step(1);
    wr(0, 3);
    step(1);
    div_wr = 1'b0;
    step(10);

    // Test 5: ch3 disable mid-period and re-enable; out-of-range write is ignored.
    cur_tid = 5;
    ch_en[3] = 1'b1;
    expect_win(3, {"000011001", rep("0", 14), "11001"}, {"000010001", rep("0", 14), "10001"},
               rep("0", 28), 1);
    step(9);
    ch_en[3] = 1'b0;
    step(3);
    wr(N_CH, 2);
    for (int ch = 0; ch < N_CH; ch++) begin
      if (ch != 3) expect_win(ch, "----", "----", "0000", 1);
    end
    step(1);
    div_wr = 1'b0;
    step(6);
    ch_en[3] = 1'b1;
    step(9);

    // Test 6: asynchronous reset mid-operation with a pending write; restart at default.
    cur_tid = 6;
    ch_en = 5'b11111;
    wr(1, 9);
    step(1);
    div_wr = 1'b0;
    step(3);
    #2;
    rst_n = 1'b0;
    #1;
    for (int ch = 0; ch < N_CH; ch++) expect_win(ch, "0", "0", "0", 0);
    chk_pulse = 1'b1;
    #1;
    chk_pulse = 1'b0;
    step(1);
    for (int ch = 0; ch < N_CH; ch++) expect_win(ch, "00", "00", "00", 1);
    step(2);
    rst_n = 1'b1;
    for (int ch = 0; ch < N_CH; ch++)
      expect_win(ch, "000011001100", "000010001000", rep("0", 12), 1);
    step(12);

    for (int k = 0; k < 50 && sb.size() > 0; k++) step(1);
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
      n_bad += sb.size();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
